// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the 4-stage pipeline and its stall/flush sequencer.
// The master side is the pipeline/hazard logic. The slave side is the sequencer.
interface pipeline_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             stall_in;
   logic             branch_taken;
   logic             muldiv_issue;
   logic             halt_req;
   logic             resume;
   logic             cnt_clr;
   logic             pc_en;
   logic             s1_en;
   logic             s2_en;
   logic             s3_en;
   logic             s1_flush;
   logic             s2_bubble;
   logic             muldiv_busy;
   logic             halted;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output stall_in, branch_taken, muldiv_issue, halt_req, resume, cnt_clr,
      input  pc_en, s1_en, s2_en, s3_en, s1_flush, s2_bubble,
      input  muldiv_busy, halted, stall_cycles
   );

   modport slave (
      input  stall_in, branch_taken, muldiv_issue, halt_req, resume, cnt_clr,
      output pc_en, s1_en, s2_en, s3_en, s1_flush, s2_bubble,
      output muldiv_busy, halted, stall_cycles
   );
endinterface

// File: rtl/pipeline_sequencer.sv
// Central stall/flush sequencer: Mealy stage controls in RUN, fixed-length MULT/DIV
// freeze, HALT with external resume, and a saturating stall-cycle counter.
module pipeline_sequencer #(
   parameter int MULDIV_CYCLES = 16,
   parameter int CNT_W         = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipeline_sequencer_if.slave  seq_if
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_MULDIV = 2'b01,
      ST_HALT   = 2'b10
   } state_e;

   localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES - 1);

   state_e           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             halt_pend_q, halt_pend_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   logic pc_en_s, s1_en_s, s2_en_s, s3_en_s;
   logic s1_flush_s, s2_bubble_s, muldiv_busy_s, halted_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (&v) begin
         r = v;
      end else begin
         r = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   // Next-state and Mealy stage-control decode
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      halt_pend_d   = halt_pend_q;
      pc_en_s       = 1'b0;
      s1_en_s       = 1'b0;
      s2_en_s       = 1'b0;
      s3_en_s       = 1'b0;
      s1_flush_s    = 1'b0;
      s2_bubble_s   = 1'b0;
      muldiv_busy_s = 1'b0;
      halted_s      = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (seq_if.halt_req) begin
               s1_flush_s = 1'b1;
               state_d    = ST_HALT;
            end else if (seq_if.branch_taken) begin
               // Branch beats a same-cycle load-use stall: no bubble, wrong-path fetch flushed
               pc_en_s    = 1'b1;
               s1_en_s    = 1'b1;
               s2_en_s    = 1'b1;
               s3_en_s    = 1'b1;
               s1_flush_s = 1'b1;
            end else if (seq_if.muldiv_issue) begin
               pc_en_s = 1'b1;
               s1_en_s = 1'b1;
               s2_en_s = 1'b1;
               s3_en_s = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = ST_MULDIV;
            end else if (seq_if.stall_in) begin
               s2_en_s     = 1'b1;
               s3_en_s     = 1'b1;
               s2_bubble_s = 1'b1;
            end else begin
               pc_en_s = 1'b1;
               s1_en_s = 1'b1;
               s2_en_s = 1'b1;
               s3_en_s = 1'b1;
            end
         end

         ST_MULDIV: begin
            muldiv_busy_s = 1'b1;
            if (cnt_q == 8'd0) begin
               halt_pend_d = 1'b0;
               if (halt_pend_q || seq_if.halt_req) begin
                  state_d = ST_HALT;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               cnt_d       = cnt_q - 8'd1;
               halt_pend_d = halt_pend_q | seq_if.halt_req;
            end
         end

         ST_HALT: begin
            halted_s = 1'b1;
            if (seq_if.resume) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_HALT;
            end
         end

         default: begin
            state_d     = ST_RUN;
            cnt_d       = 8'd0;
            halt_pend_d = 1'b0;
         end
      endcase
   end

   // Stall-cycle counter next value; clear has priority over a counted cycle
   always_comb begin
      if (seq_if.cnt_clr) begin
         stall_cycles_d = {CNT_W{1'b0}};
      end else if (!pc_en_s && (state_q != ST_HALT)) begin
         stall_cycles_d = sat_inc(stall_cycles_q);
      end else begin
         stall_cycles_d = stall_cycles_q;
      end
   end

   // Sequencer state, freeze counter, deferred halt and performance counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_RUN;
         cnt_q          <= 8'd0;
         halt_pend_q    <= 1'b0;
         stall_cycles_q <= {CNT_W{1'b0}};
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         halt_pend_q    <= halt_pend_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   // Controls are gated by rst_n so the pipeline is frozen as soon as reset asserts
   assign seq_if.pc_en        = pc_en_s       & rst_n;
   assign seq_if.s1_en        = s1_en_s       & rst_n;
   assign seq_if.s2_en        = s2_en_s       & rst_n;
   assign seq_if.s3_en        = s3_en_s       & rst_n;
   assign seq_if.s1_flush     = s1_flush_s    & rst_n;
   assign seq_if.s2_bubble    = s2_bubble_s   & rst_n;
   assign seq_if.muldiv_busy  = muldiv_busy_s & rst_n;
   assign seq_if.halted       = halted_s      & rst_n;
   assign seq_if.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed and randomized bench for pipeline_sequencer against a behavioural model
// that tracks remaining freeze cycles, halt status and a saturating stall count.
module tb_pipeline_sequencer;
   localparam int MD = 4;
   localparam int CW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   pipeline_sequencer_if #(.CNT_W(CW)) bus ();

   pipeline_sequencer #(.MULDIV_CYCLES(MD), .CNT_W(CW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .seq_if (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int freeze_left;
   int cnt_m;
   bit halted_m;
   bit pend_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] out_vec();
      return {bus.pc_en, bus.s1_en, bus.s2_en, bus.s3_en,
              bus.s1_flush, bus.s2_bubble, bus.muldiv_busy, bus.halted};
   endfunction

   task automatic model_reset();
      freeze_left = 0;
      cnt_m       = 0;
      halted_m    = 1'b0;
      pend_m      = 1'b0;
   endtask

   // One clock cycle: drive after the falling edge, check, cross the rising edge, update model
   task automatic step(input bit st, input bit br, input bit md, input bit hr,
                       input bit rs, input bit cc, input string tag);
      logic [7:0] e;
      int  n_freeze, n_cnt;
      bit  n_halted, n_pend;
      bus.stall_in     = st;
      bus.branch_taken = br;
      bus.muldiv_issue = md;
      bus.halt_req     = hr;
      bus.resume       = rs;
      bus.cnt_clr      = cc;
      #1;
      // bit order: pc_en s1_en s2_en s3_en s1_flush s2_bubble muldiv_busy halted
      if (halted_m)             e = 8'b0000_0001;
      else if (freeze_left > 0) e = 8'b0000_0010;
      else if (hr)              e = 8'b0000_1000;
      else if (br)              e = 8'b1111_1000;
      else if (md)              e = 8'b1111_0000;
      else if (st)              e = 8'b0011_0100;
      else                      e = 8'b1111_0000;
      chk({tag, "_out"}, {24'd0, out_vec()}, {24'd0, e});
      chk({tag, "_cnt"}, {28'd0, bus.stall_cycles}, cnt_m);

      n_freeze = freeze_left;
      n_halted = halted_m;
      n_pend   = pend_m;
      if (cc)                               n_cnt = 0;
      else if (!e[7] && !halted_m && cnt_m < 15) n_cnt = cnt_m + 1;
      else                                  n_cnt = cnt_m;
      if (halted_m) begin
         if (rs) n_halted = 1'b0;
      end else if (freeze_left > 0) begin
         n_freeze = freeze_left - 1;
         if (hr) n_pend = 1'b1;
         if (n_freeze == 0) begin
            n_halted = n_pend;
            n_pend   = 1'b0;
         end
      end else if (hr) begin
         n_halted = 1'b1;
      end else if (!br && md) begin
         n_freeze = MD;
      end

      @(posedge clk);
      freeze_left = n_freeze;
      cnt_m       = n_cnt;
      halted_m    = n_halted;
      pend_m      = n_pend;
      @(negedge clk);
   endtask

   initial begin
      bus.stall_in     = 1'b0;
      bus.branch_taken = 1'b0;
      bus.muldiv_issue = 1'b0;
      bus.halt_req     = 1'b0;
      bus.resume       = 1'b0;
      bus.cnt_clr      = 1'b0;
      model_reset();
      #2;
      chk("reset_out", {24'd0, out_vec()}, 32'd0);
      chk("reset_cnt", {28'd0, bus.stall_cycles}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      step(0, 0, 0, 0, 0, 0, "idle");
      step(1, 0, 0, 0, 0, 0, "loaduse");
      chk("loaduse_count", {28'd0, bus.stall_cycles}, 32'd1);
      step(0, 0, 0, 0, 0, 0, "after_stall");

      step(0, 0, 1, 0, 0, 0, "md_issue");
      step(0, 0, 0, 0, 0, 0, "md_f1");
      step(0, 1, 0, 0, 0, 0, "md_f2_branch");
      step(1, 0, 1, 0, 0, 0, "md_f3_ignored");
      step(0, 0, 0, 0, 0, 0, "md_f4");
      chk("md_count", {28'd0, bus.stall_cycles}, 32'd5);
      step(0, 0, 0, 0, 0, 0, "md_done");

      step(0, 0, 1, 0, 0, 0, "hd_issue");
      step(0, 0, 0, 0, 0, 0, "hd_f1");
      step(0, 0, 0, 1, 0, 0, "hd_f2_halt");
      step(0, 0, 0, 0, 0, 0, "hd_f3");
      step(0, 0, 0, 0, 0, 0, "hd_f4");
      step(1, 1, 1, 0, 0, 0, "hd_halted");
      step(0, 0, 0, 0, 1, 0, "hd_resume");
      step(0, 0, 0, 0, 0, 0, "hd_running");

      step(1, 1, 0, 0, 0, 0, "br_vs_stall");
      step(1, 1, 1, 1, 0, 0, "halt_prio");
      step(0, 0, 0, 0, 0, 0, "halt_hold");
      step(0, 0, 0, 0, 1, 0, "halt_resume");
      step(0, 0, 0, 0, 0, 0, "halt_exit");

      step(0, 0, 0, 0, 0, 1, "sat_clear");
      for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, "sat_stall");
      chk("sat_value", {28'd0, bus.stall_cycles}, 32'd15);
      step(1, 0, 0, 0, 0, 1, "clr_vs_inc");
      chk("clr_wins", {28'd0, bus.stall_cycles}, 32'd0);
      step(0, 0, 0, 0, 0, 0, "after_clr");

      step(0, 0, 1, 0, 0, 0, "rm_issue");
      step(0, 0, 0, 1, 0, 0, "rm_f1");
      #3;
      rst_n = 1'b0;
      #1;
      chk("rm_async_out", {24'd0, out_vec()}, 32'd0);
      chk("rm_async_cnt", {28'd0, bus.stall_cycles}, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 0, "rm_after");

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(99) < 30, $urandom_range(99) < 15,
              $urandom_range(99) < 15, $urandom_range(99) < 5,
              $urandom_range(99) < 30, $urandom_range(99) < 4, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
